// File: rtl/pcm_play_ctrl.sv
// PCM playback controller: IDLE/PLAY/PAUSE/DONE FSM that paces reads from a PCM BRAM
// and delivers each sample two cycles after its divider strobe, with exact progress scaling.
module pcm_play_ctrl #(
  parameter int SONG_LEN   = 75611,
  parameter int SAMPLE_DIV = 12500,
  parameter int PROG_STEPS = 140
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        play_btn,
  input  logic        stop_btn,
  input  logic        loop_en,
  output logic [16:0] bram_addr,
  input  logic [7:0]  bram_dout,
  output logic [7:0]  audio_data,
  output logic        audio_valid,
  output logic [1:0]  state,
  output logic [7:0]  progress
);

  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int ACC_W = $clog2(SONG_LEN + PROG_STEPS + 1);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [16:0]      POS_LAST  = 17'(SONG_LEN - 1);
  localparam logic [ACC_W-1:0] ACC_STEP  = ACC_W'(PROG_STEPS);
  localparam logic [ACC_W-1:0] ACC_MOD   = ACC_W'(SONG_LEN);
  localparam logic [7:0]       PROG_FULL = 8'(PROG_STEPS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           st;
  logic [16:0]      pos;
  logic [DIV_W-1:0] div_cnt;
  logic [ACC_W-1:0] acc;
  logic             cap_pend;

  logic             strobe;
  logic             last;
  logic [ACC_W-1:0] acc_sum;

  assign strobe    = (st == PLAY) && (div_cnt == DIV_LAST);
  assign last      = (pos == POS_LAST);
  assign acc_sum   = acc + ACC_STEP;
  assign bram_addr = pos;
  assign state     = st;

  always_ff @(posedge clk) begin
    if (rst || stop_btn) begin
      st          <= IDLE;
      pos         <= '0;
      div_cnt     <= '0;
      acc         <= '0;
      progress    <= '0;
      audio_data  <= '0;
      audio_valid <= 1'b0;
      cap_pend    <= 1'b0;
    end else begin
      // BRAM word for the strobe address is valid the cycle after the strobe;
      // a capture in flight completes even if the FSM has left PLAY meanwhile.
      cap_pend    <= strobe;
      audio_valid <= cap_pend;
      if (cap_pend)
        audio_data <= bram_dout;
      else if (st == IDLE || st == DONE)
        audio_data <= '0;

      case (st)
        IDLE, DONE: begin
          if (play_btn) begin
            st       <= PLAY;
            pos      <= '0;
            div_cnt  <= '0;
            acc      <= '0;
            progress <= '0;
          end
        end

        PLAY: begin
          if (strobe) begin
            div_cnt <= '0;
            if (last && !loop_en) begin
              st       <= DONE;
              progress <= PROG_FULL;
            end else begin
              if (play_btn)
                st <= PAUSE;
              if (last) begin
                pos      <= '0;
                acc      <= '0;
                progress <= '0;
              end else begin
                pos <= pos + 17'd1;
                // acc holds (samples * PROG_STEPS) mod SONG_LEN, so progress stays exact
                if (acc_sum >= ACC_MOD) begin
                  acc <= acc_sum - ACC_MOD;
                  if (progress < PROG_FULL)
                    progress <= progress + 8'd1;
                end else begin
                  acc <= acc_sum;
                end
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
            if (play_btn)
              st <= PAUSE;
          end
        end

        PAUSE: begin
          if (play_btn)
            st <= PLAY;
        end

        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcm_play_ctrl.sv
// Bench for pcm_play_ctrl: directed vector table plus random button traffic, all checked
// every cycle against a sample-count based reference model.
module tb_pcm_play_ctrl;

  localparam int L = 10;
  localparam int D = 4;
  localparam int P = 5;

  logic        clk = 1'b0;
  logic        rst, play_btn, stop_btn, loop_en;
  logic [16:0] bram_addr;
  logic [7:0]  bram_dout;
  logic [7:0]  audio_data;
  logic        audio_valid;
  logic [1:0]  state;
  logic [7:0]  progress;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pcm_play_ctrl #(.SONG_LEN(L), .SAMPLE_DIV(D), .PROG_STEPS(P)) dut (
    .clk(clk), .rst(rst), .play_btn(play_btn), .stop_btn(stop_btn), .loop_en(loop_en),
    .bram_addr(bram_addr), .bram_dout(bram_dout), .audio_data(audio_data),
    .audio_valid(audio_valid), .state(state), .progress(progress)
  );

  // BRAM image: word n = 0x10 + n, one-cycle registered read
  always_ff @(posedge clk) bram_dout <= 8'h10 + bram_addr[7:0];

  // Reference model: song position derived from PLAY cycles elapsed, deliveries queued by due cycle.
  typedef struct { int due; logic [7:0] v; } dlv_t;
  dlv_t       q[$];
  int         m_st = 0;
  int         m_cyc = 0;
  int         now = 0;
  logic [7:0] m_data = 8'h00;
  logic       m_valid = 1'b0;

  function automatic int m_pos();
    return (m_st == 3) ? L - 1 : (m_cyc / D) % L;
  endfunction

  function automatic int m_prog();
    return (m_st == 3) ? P : (((m_cyc / D) % L) * P) / L;
  endfunction

  task automatic model_step(input logic r, input logic p, input logic s, input logic l);
    bit strobe;
    int spos;
    now++;
    if (r || s) begin
      m_st = 0; m_cyc = 0; m_data = 8'h00; m_valid = 1'b0;
      q.delete();
      return;
    end
    m_valid = 1'b0;
    if (q.size() > 0 && q[0].due == now) begin
      m_valid = 1'b1;
      m_data  = q[0].v;
      void'(q.pop_front());
    end else if (m_st == 0 || m_st == 3) begin
      m_data = 8'h00;
    end
    strobe = (m_st == 1) && ((m_cyc % D) == D - 1);
    spos   = (m_cyc / D) % L;
    if (strobe) q.push_back('{now + 1, 8'(8'h10 + spos)});
    case (m_st)
      0, 3: if (p) begin m_st = 1; m_cyc = 0; end
      1: begin
        if (strobe && spos == L - 1 && !l) m_st = 3;
        else begin
          m_cyc++;
          if (p) m_st = 2;
        end
      end
      default: if (p) m_st = 1;
    endcase
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic cycle(input logic r, input logic p, input logic s, input logic l);
    rst = r; play_btn = p; stop_btn = s; loop_en = l;
    @(posedge clk);
    model_step(r, p, s, l);
    @(negedge clk);
    chk("model state", int'(state), m_st);
    chk("model bram_addr", int'(bram_addr), m_pos());
    chk("model progress", int'(progress), m_prog());
    chk("model audio_valid", int'(audio_valid), int'(m_valid));
    chk("model audio_data", int'(audio_data), int'(m_data));
  endtask

  typedef struct {
    logic r, p, s, l;
    int   n;
    int   e_st, e_addr, e_prog, e_data, e_vld;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic r, input logic p, input logic s, input logic l, input int n,
                              input int st, input int a, input int pr, input int d, input int v);
    vec_t x;
    x = '{r, p, s, l, n, st, a, pr, d, v};
    tbl.push_back(x);
  endfunction

  logic lp = 1'b0;

  initial begin
    rst = 1'b1; play_btn = 1'b0; stop_btn = 1'b0; loop_en = 1'b0;
    @(negedge clk);

    //   r  p  s  l   n   state addr prog data vld
    // basic play to DONE, then restart from DONE, then stop+play together
    add(1, 0, 0, 0,  1,  0, 0, 0, 8'h00, 0);
    add(0, 1, 0, 0,  1,  1, 0, 0, 8'h00, 0);
    add(0, 0, 0, 0,  5,  1, 1, 0, 8'h10, 1);
    add(0, 0, 0, 0,  4,  1, 2, 1, 8'h11, 1);
    add(0, 0, 0, 0, 32,  3, 9, 5, 8'h19, 1);
    add(0, 0, 0, 0,  1,  3, 9, 5, 8'h00, 0);
    add(0, 1, 0, 0,  6,  1, 1, 0, 8'h10, 1);
    add(0, 1, 1, 0,  1,  0, 0, 0, 8'h00, 0);
    add(0, 0, 0, 0, 10,  0, 0, 0, 8'h00, 0);
    // pause after 3 samples, hold 20 cycles, resume
    add(0, 1, 0, 0, 14,  1, 3, 1, 8'h12, 1);
    add(0, 1, 0, 0, 21,  2, 3, 1, 8'h12, 0);
    add(0, 1, 0, 0,  4,  1, 4, 2, 8'h13, 1);
    add(0, 0, 1, 0,  1,  0, 0, 0, 8'h00, 0);
    // looping: wrap after sample 10, 25th sample is 0x14
    add(0, 1, 0, 1, 42,  1, 0, 0, 8'h19, 1);
    add(0, 0, 0, 1, 60,  1, 5, 2, 8'h14, 1);
    add(0, 0, 1, 0,  1,  0, 0, 0, 8'h00, 0);
    // reset one cycle after a strobe cancels the capture in flight
    add(0, 1, 0, 0,  5,  1, 1, 0, 8'h00, 0);
    add(1, 0, 0, 0,  1,  0, 0, 0, 8'h00, 0);
    add(0, 0, 0, 0,  3,  0, 0, 0, 8'h00, 0);

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        if (k == 0) cycle(tbl[i].r, tbl[i].p, tbl[i].s, tbl[i].l);
        else        cycle(1'b0, 1'b0, 1'b0, tbl[i].l);
      end
      chk($sformatf("vec%0d state", i), int'(state), tbl[i].e_st);
      chk($sformatf("vec%0d bram_addr", i), int'(bram_addr), tbl[i].e_addr);
      chk($sformatf("vec%0d progress", i), int'(progress), tbl[i].e_prog);
      chk($sformatf("vec%0d audio_data", i), int'(audio_data), tbl[i].e_data);
      chk($sformatf("vec%0d audio_valid", i), int'(audio_valid), tbl[i].e_vld);
    end

    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 49) == 0) lp = ~lp;
      cycle($urandom_range(0, 399) == 0, $urandom_range(0, 11) == 0,
            $urandom_range(0, 79) == 0, lp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pcm_play_ctrl.md
PCM_PLAY_CTRL -- requirements
Module: pcm_play_ctrl

Interface
REQ-001 SHALL have parameter SONG_LEN, default 75611, samples in the BRAM image.
REQ-002 SHALL have parameter SAMPLE_DIV, default 12500, clk cycles per sample period.
REQ-003 SHALL have parameter PROG_STEPS, default 140, full-scale progress value.
REQ-004 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port play_btn, input, 1, one-cycle pulse that toggles play/pause.
REQ-007 SHALL have port stop_btn, input, 1, one-cycle pulse that stops and rewinds.
REQ-008 SHALL have port loop_en, input, 1, restart at end of song when 1.
REQ-009 SHALL have port bram_addr, output, 17, read address to the single-port PCM BRAM (1-cycle registered read).
REQ-010 SHALL have port bram_dout, input, 8, BRAM read data.
REQ-011 SHALL have port audio_data, output, 8, current PCM sample.
REQ-012 SHALL have port audio_valid, output, 1, one-cycle pulse when audio_data updates.
REQ-013 SHALL have port state, output, 2, IDLE=0, PLAY=1, PAUSE=2, DONE=3.
REQ-014 SHALL have port progress, output, 8, 0..PROG_STEPS progress-bar position.

Function
REQ-015 SHALL implement FSM IDLE/PLAY/PAUSE/DONE.
REQ-016 SHALL apply these transitions on play_btn: IDLE->PLAY, PLAY->PAUSE, PAUSE->PLAY, DONE->PLAY.
REQ-017 SHALL, on stop_btn in any state, go to IDLE with position 0, progress 0, divider 0, and audio_data 0; stop_btn wins over a simultaneous play_btn.
REQ-018 SHALL clear position, divider, progress and the progress accumulator on entry to PLAY from IDLE or DONE; PAUSE->PLAY resumes with all of them unchanged.
REQ-019 SHALL run divider div_cnt 0..SAMPLE_DIV-1 only in PLAY, freeze it in PAUSE, and assert the internal sample strobe in the PLAY cycle where div_cnt==SAMPLE_DIV-1.
REQ-020 SHALL drive bram_addr from the position register pos; pos is 17 bits and always 0..SONG_LEN-1.
REQ-021 SHALL, for a strobe at cycle T, update audio_data to the BRAM word at pos(T) and pulse audio_valid in cycle T+2; pos advances at the end of cycle T.
REQ-022 SHALL complete a data capture already in flight when the FSM leaves PLAY for PAUSE; stop_btn or rst cancels it.
REQ-023 SHALL hold audio_data at its last value in PAUSE and force it to 0 in IDLE and DONE.
REQ-024 SHALL, on a strobe with pos==SONG_LEN-1 and loop_en=1, set pos to 0, progress to 0 and the accumulator to 0, and stay in PLAY.
REQ-025 SHALL, on a strobe with pos==SONG_LEN-1 and loop_en=0, still deliver that last sample, then enter DONE in cycle T+1 with progress==PROG_STEPS.
REQ-026 SHALL update progress exactly using an accumulator acc (width sufficient for SONG_LEN+PROG_STEPS) on each non-wrapping strobe: if acc+PROG_STEPS>=SONG_LEN then acc<=acc+PROG_STEPS-SONG_LEN and progress<=progress+1, else acc<=acc+PROG_STEPS.
REQ-027 SHALL keep progress saturated at PROG_STEPS and never exceed it.
REQ-028 SHALL ignore play_btn and stop_btn pulses other than as listed in REQ-016 and REQ-017, and keep its state when loop_en changes mid-song; loop_en is sampled only at the end-of-song strobe.

Reset
REQ-029 SHALL, when rst=1 at a clk edge, set state=IDLE, pos=0, bram_addr=0, div_cnt=0, acc=0, progress=0, audio_data=0 and audio_valid=0, and cancel any pending capture.
REQ-030 SHALL give rst priority over all other inputs, including assertion mid-PLAY.

Verification
All scenarios use SONG_LEN=10, SAMPLE_DIV=4, PROG_STEPS=5, and BRAM word n = 0x10+n.
REQ-031 Basic play: rst, play_btn -> first audio_valid 5 cycles after the PLAY entry with audio_data=0x10, then 0x11..0x19 every 4 cycles; progress 1,2,3,4,5 after samples 2,4,6,8,10; state=DONE; audio_data=0 afterwards.
REQ-032 Pause/resume: pause after 3 samples, hold 20 cycles -> no audio_valid, audio_data=0x12 held, bram_addr=3; resume -> next sample 0x13 exactly 4 cycles after resume.
REQ-033 Loop: loop_en=1, play 25 samples -> sequence 0x10..0x19,0x10..0x19,0x10..0x14; progress wraps to 0 after sample 10; state stays PLAY.
REQ-034 Stop plus play in the same cycle mid-song -> state=IDLE, pos=0, progress=0, audio_data=0, no further audio_valid.
REQ-035 Reset mid-PLAY, asserted 1 cycle after a strobe -> no audio_valid, all outputs zero, state=IDLE next cycle.
REQ-036 DONE then play_btn -> restart from 0x10 with progress 0.
